// File: rtl/ysyx_220053_mdu_pkg.sv
// Shared encodings, FSM state type and op-decode helpers for the RV64M sequencer.
package ysyx_220053_mdu_pkg;

  localparam logic [2:0] MDU_MUL   = 3'b000;
  localparam logic [2:0] MDU_MULHU = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_REMU  = 3'b101;
  localparam logic [2:0] MDU_DIV   = 3'b110;
  localparam logic [2:0] MDU_REM   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // bit_in: multiplier LSB (add enable) for MUL, next dividend bit for DIV
  typedef struct packed {
    logic is_div;
    logic bit_in;
  } mdu_mode_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic want_hi_or_rem(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/ysyx_220053_mdu_step.sv
// One combinational multiply/divide iteration around the single shared XLEN+1 adder/subtractor.
module ysyx_220053_mdu_step
  import ysyx_220053_mdu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] operand,
  input  mdu_mode_t       mode,
  output logic [XLEN-1:0] acc_nxt,
  output logic            q_bit
);

  localparam int unsigned AW = XLEN + 1;

  logic [AW-1:0] add_a;
  logic [AW-1:0] add_b;
  logic [AW:0]   sum;

  // Divide: a - b via a + ~b + 1, carry-out set means the trial subtract fits.
  always_comb begin
    if (mode.is_div) begin
      add_a = {acc, mode.bit_in};
      add_b = ~{1'b0, operand};
    end else begin
      add_a = {1'b0, acc};
      add_b = mode.bit_in ? {1'b0, operand} : '0;
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + (AW + 1)'(mode.is_div);
    if (mode.is_div) begin
      q_bit   = sum[AW];
      acc_nxt = sum[AW] ? sum[XLEN-1:0] : add_a[XLEN-1:0];
    end else begin
      q_bit   = sum[0];
      acc_nxt = sum[AW-1:1];
    end
  end

endmodule

// File: rtl/ysyx_220053_muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer, one bit per cycle with valid/ready result handshake.
// Optional YSYX_220053_MDU_EARLY_OUT_EN: zero operands / zero divisor skip the CALC phase.
module ysyx_220053_muldiv_seq
  import ysyx_220053_mdu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  mdu_mode_t       mode;
  logic [XLEN-1:0] acc_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic [XLEN-1:0] fin;
  logic            q_bit;
  logic            src1_neg, src2_neg;
  logic [XLEN-1:0] src1_mag, src2_mag;

  // Operand magnitudes for signed divide, and the step's per-cycle mode.
  always_comb begin
    src1_neg    = is_signed(op) & src1[XLEN-1];
    src2_neg    = is_signed(op) & src2[XLEN-1];
    src1_mag    = src1_neg ? (~src1 + XLEN'(1)) : src1;
    src2_mag    = src2_neg ? (~src2 + XLEN'(1)) : src2;
    mode.is_div = is_div(op_q);
    mode.bit_in = is_div(op_q) ? lo_q[XLEN-1] : lo_q[0];
  end

  ysyx_220053_mdu_step #(.XLEN(XLEN)) u_step (
    .acc     (acc_q),
    .operand (opnd_q),
    .mode    (mode),
    .acc_nxt (acc_nxt),
    .q_bit   (q_bit)
  );

  // MUL shifts the product right into lo; DIV shifts dividend out / quotient in on the left.
  always_comb begin
    lo_nxt = is_div(op_q) ? {lo_q[XLEN-2:0], q_bit} : {q_bit, lo_q[XLEN-1:1]};
    if (!is_div(op_q)) begin
      fin = want_hi_or_rem(op_q) ? acc_nxt : lo_nxt;
    end else if (want_hi_or_rem(op_q)) begin
      fin = (is_signed(op_q) && neg_rem_q) ? (~acc_nxt + XLEN'(1)) : acc_nxt;
    end else begin
      fin = (is_signed(op_q) && neg_quo_q) ? (~lo_nxt + XLEN'(1)) : lo_nxt;
    end
  end

`ifdef YSYX_220053_MDU_EARLY_OUT_EN
  logic            early;
  logic [XLEN-1:0] early_val;

  always_comb begin
    early = (src1 == '0) || (src2 == '0);
    if (is_div(op) && (src2 == '0)) begin
      early_val = want_hi_or_rem(op) ? src1 : '1;
    end else begin
      early_val = '0;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d   = CALC;
            cnt_d     = '0;
            op_d      = op;
            acc_d     = '0;
            lo_d      = is_div(op) ? src1_mag : src2;
            opnd_d    = is_div(op) ? src2_mag : src1;
            // A zero divisor keeps the all-ones quotient unsigned-looking.
            neg_quo_d = (src1_neg ^ src2_neg) & (src2 != '0);
            neg_rem_d = src1_neg;
`ifdef YSYX_220053_MDU_EARLY_OUT_EN
            if (early) begin
              state_d  = DONE;
              result_d = early_val;
            end
`endif
          end
        end
        CALC: begin
          acc_d = acc_nxt;
          lo_d  = lo_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d  = DONE;
            result_d = fin;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= MDU_MUL;
      acc_q       <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
